// File: rtl/adc_capture_ctrl_if.sv
// Output sample stream of adc_capture_ctrl.
//   m_data  : head-of-FIFO sample (producer -> consumer)
//   m_valid : m_data holds a sample (producer -> consumer)
//   m_ready : consumer accepts m_data this cycle (consumer -> producer)
// A sample transfers on every clock where m_valid && m_ready.
interface adc_capture_ctrl_if #(
  parameter int WDTH = 16
);
  logic [WDTH-1:0] m_data;
  logic            m_valid;
  logic            m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Capture controller for the sigma_delta_adc datapath.
// After start it enables the ADC, throws away the first SETTLE decimator
// samples, then buffers num_samples samples (0 = until abort) in a FIFO
// that drains over a valid/ready stream. done pulses when a counted capture
// has fully drained.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : single-cycle capture request / cancel
//   num_samples       : capture length, latched on accepted start
//   adc_en            : ADC enable (SETTLE and CAPTURE only)
//   adc_output/valid  : decimated sample and its one-cycle qualifier
//   m_if              : output stream (master side)
//   busy/done/overflow: status; overflow is sticky until next start
module adc_capture_ctrl #(
  parameter int WDTH   = 16,
  parameter int SETTLE = 4,
  parameter int DEPTH  = 8,
  parameter int CW     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CW-1:0]         num_samples,
  output logic                  adc_en,
  input  logic [WDTH-1:0]       adc_output,
  input  logic                  adc_valid,
  adc_capture_ctrl_if.master    m_if,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   num_q, num_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            adc_en_q, adc_en_d;
  logic            rst_done_q;
  logic [WDTH-1:0] mem_q [DEPTH];

  logic            fifo_empty, fifo_full, pop, push, flush;
  logic [CW-1:0]   cnt_inc;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && m_if.m_ready;
  assign cnt_inc    = cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    flush    = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // rst_done_q holds off the first edge after reset release.
        if (rst_done_q && start && !abort) begin
          num_d   = num_samples;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          flush   = 1'b1;
          state_d = (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (adc_valid) begin
          if (cnt_inc == SETTLE_C) begin
            cnt_d   = '0;
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (adc_valid) begin
          cnt_d = cnt_inc;
          // A pop in the same cycle frees the slot, so full only drops then.
          if (fifo_full && !pop) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
          end
          if ((num_q != '0) && (cnt_inc == num_q)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (fifo_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    adc_en_d = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      adc_en_q   <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      adc_en_q   <= adc_en_d;
      rst_done_q <= 1'b1;
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= adc_output;
    end
  end

  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign adc_en       = adc_en_q;
  assign busy         = (state_q != ST_IDLE);
  assign overflow     = ovf_q;

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter WDTH, default 16, ADC sample width (matches sigma_delta_adc WDTH).
REQ-002 SHALL have parameter SETTLE, default 4, number of decimator output samples discarded after enable.
REQ-003 SHALL have parameter DEPTH, default 8, output FIFO entries, power of two, >= 2.
REQ-004 SHALL have parameter CW, default 16, width of the sample-count request.
REQ-005 SHALL have port clk  in  1  single clock for all logic; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start  in  1  single-cycle capture request.
REQ-008 SHALL have port abort  in  1  single-cycle cancel request.
REQ-009 SHALL have port num_samples  in  CW  samples to capture, sampled on accepted start; 0 = continuous.
REQ-010 SHALL have port adc_en  out  1  enable to the sigma_delta_adc datapath.
REQ-011 SHALL have port adc_output  in  WDTH  decimated ADC sample.
REQ-012 SHALL have port adc_valid  in  1  adc_output qualifier, one-cycle pulse per sample.
REQ-013 SHALL have ports m_data out WDTH, m_valid out 1, m_ready in 1: output stream, valid/ready handshake.
REQ-014 SHALL have ports busy out 1 (state != IDLE), done out 1 (one-cycle completion pulse), overflow out 1 (sticky drop flag).

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, CAPTURE, DRAIN.
REQ-016 IDLE: adc_en=0; start (without abort) -> SETTLE if SETTLE>0, else CAPTURE; latch num_samples, clear counters, flush FIFO, clear overflow.
REQ-017 adc_en SHALL be 1 in SETTLE and CAPTURE only, registered, asserted the cycle after start is accepted.
REQ-018 SETTLE: count adc_valid pulses; these samples are never written; on the SETTLE-th pulse -> CAPTURE.
REQ-019 CAPTURE: each adc_valid pushes adc_output into FIFO and increments the capture count (CW bits).
REQ-020 CAPTURE push when FIFO full and no pop that cycle: sample dropped, overflow set, count still increments.
REQ-021 CAPTURE push when full with simultaneous pop: write accepted, no overflow.
REQ-022 CAPTURE: when count reaches latched num_samples (nonzero) -> DRAIN; adc_valid pulses in DRAIN ignored.
REQ-023 latched num_samples=0: remain in CAPTURE until abort; count wraps without effect.
REQ-024 DRAIN: when FIFO empty -> IDLE, done=1 for exactly that transition cycle.
REQ-025 abort in any non-IDLE state: -> IDLE next cycle, FIFO flushed, adc_en=0, no done pulse; overflow retained.
REQ-026 start while busy SHALL be ignored; start and abort same cycle in IDLE: abort wins, stay IDLE.
REQ-027 m_valid = FIFO not empty; m_data = head entry, stable while m_valid && !m_ready; pop on m_valid && m_ready.
REQ-028 latency: adc_valid at cycle N into empty FIFO -> m_valid=1 with that sample at cycle N+1.
REQ-029 FIFO SHALL use wrap-around read/write pointers of log2(DEPTH)+1 bits; full/empty from pointer compare.
REQ-030 sample order SHALL be preserved; no sample duplicated.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, adc_en=0, m_valid=0, m_data=0, busy=0, done=0, overflow=0, FIFO empty, counters 0.
REQ-032 reset deassertion SHALL be synchronized; first start honored on second clk edge after rst_n rises.
REQ-033 reset mid-capture SHALL discard all buffered samples; no done pulse.

Verification
REQ-034 SETTLE=4, num_samples=3, m_ready=1, samples 1..7 -> samples 1-4 discarded; m_data 5,6,7; done one cycle after 7 pops; adc_en low.
REQ-035 num_samples=12, DEPTH=8, m_ready=0 -> 8 stored, overflow=1 after 9th; raise m_ready -> first 8 samples out in order, then done.
REQ-036 full FIFO, push and pop same cycle -> occupancy stays 8, overflow stays 0.
REQ-037 num_samples=0, stream 20 samples, abort -> next cycle busy=0, m_valid=0, adc_en=0, done never pulses.
REQ-038 start while in CAPTURE with num_samples changed -> ignored, original count completes; start+abort in IDLE -> stays IDLE.
REQ-039 rst_n low mid-CAPTURE (async, between edges) -> outputs per REQ-031 immediately; new start after release works normally.
